// File: rtl/pwm_pkg.sv
// Shared constants and state encoding for the PWM generator/capture pair.
package pwm_pkg;

    localparam int PWM_WIDTH   = 8;
    localparam int PWM_PERIOD  = 256;
    localparam int PWM_TIMEOUT = 512;

    typedef enum logic {
        SYNC = 1'b0,
        MEAS = 1'b1
    } state_t;

endpackage

// File: rtl/pwm_capture_if.sv
// Result bus of the PWM capture: recovered duty plus status flags, strobed by valid.
interface pwm_capture_if #(
    parameter int WIDTH = pwm_pkg::PWM_WIDTH
);

    logic [WIDTH-1:0] value;
    logic             valid;
    logic             stuck;
    logic             period_err;

    modport master (output value, valid, stuck, period_err);
    modport slave  (input  value, valid, stuck, period_err);

endinterface

// File: rtl/pwm_capture_sync_rise.sv
// Two-flop synchronizer for the asynchronous PWM line plus a rising-edge detector.
module sync_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic s2,
    output logic rise
);

    // sh_reg[0]=s1, sh_reg[1]=s2, sh_reg[2]=s3 (delayed copy of s2)
    logic [2:0] sh_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_reg <= '0;
        end else begin
            sh_reg <= {sh_reg[1:0], din};
        end
    end

    assign s2   = sh_reg[1];
    assign rise = sh_reg[1] & ~sh_reg[2];

endmodule

// File: rtl/pwm_capture.sv
// Recovers the duty value of an incoming PWM waveform, one result per rising-edge-to-rising-edge
// period, and reports a stuck line after TIMEOUT cycles without a rising edge.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int WIDTH   = PWM_WIDTH,
    parameter int PERIOD  = PWM_PERIOD,
    parameter int TIMEOUT = PWM_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pwm_in,
    pwm_capture_if.master cap
);

    localparam int PW = $clog2(TIMEOUT) + 1;
    localparam int HW = WIDTH + 1;
    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

    logic s2;
    logic rise;

    sync_rise u_sync_rise (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (pwm_in),
        .s2   (s2),
        .rise (rise)
    );

    state_t           state_reg, state_next;
    logic [PW-1:0]    per_cnt_reg, per_cnt_next;
    logic [HW-1:0]    high_cnt_reg, high_cnt_next;
    logic [WIDTH-1:0] value_reg, value_next;
    logic             valid_reg, valid_next;
    logic             stuck_reg, stuck_next;
    logic             period_err_reg, period_err_next;

    logic [PW-1:0] per_inc;
    logic [HW-1:0] high_inc;
    logic          timeout_hit;

    // Counters saturate at all-ones instead of wrapping.
    assign per_inc     = (per_cnt_reg == '1) ? per_cnt_reg : per_cnt_reg + PW'(1);
    assign high_inc    = (high_cnt_reg == '1) ? high_cnt_reg : high_cnt_reg + HW'(s2);
    assign timeout_hit = (per_inc >= PW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= SYNC;
            per_cnt_reg    <= '0;
            high_cnt_reg   <= '0;
            value_reg      <= '0;
            valid_reg      <= 1'b0;
            stuck_reg      <= 1'b0;
            period_err_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            per_cnt_reg    <= per_cnt_next;
            high_cnt_reg   <= high_cnt_next;
            value_reg      <= value_next;
            valid_reg      <= valid_next;
            stuck_reg      <= stuck_next;
            period_err_reg <= period_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        per_cnt_next    = per_cnt_reg;
        high_cnt_next   = high_cnt_reg;
        value_next      = value_reg;
        valid_next      = 1'b0;
        stuck_next      = stuck_reg;
        period_err_next = period_err_reg;

        // A rising edge takes priority over a coincident timeout.
        if (rise) begin
            if (state_reg == MEAS) begin
                value_next      = (high_cnt_reg > {1'b0, MAX_VAL}) ? MAX_VAL : high_cnt_reg[WIDTH-1:0];
                period_err_next = (per_cnt_reg != PW'(PERIOD));
                stuck_next      = 1'b0;
                valid_next      = 1'b1;
            end
            state_next    = MEAS;
            per_cnt_next  = PW'(1);
            high_cnt_next = HW'(1);
        end else if (timeout_hit) begin
            value_next      = s2 ? MAX_VAL : '0;
            stuck_next      = 1'b1;
            period_err_next = 1'b0;
            valid_next      = 1'b1;
            state_next      = SYNC;
            per_cnt_next    = '0;
            high_cnt_next   = '0;
        end else begin
            per_cnt_next = per_inc;
            if (state_reg == MEAS) begin
                high_cnt_next = high_inc;
            end
        end
    end

    assign cap.value      = value_reg;
    assign cap.valid      = valid_reg;
    assign cap.stuck      = stuck_reg;
    assign cap.period_err = period_err_reg;

endmodule

// File: tb/tb_pwm_capture.sv
// Drives directed and randomized PWM waveforms into pwm_capture and compares every cycle
// against an edge-history reference model.
module tb_pwm_capture;
    import pwm_pkg::*;

    localparam int MAXE = 16384;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pwm_in = 1'b0;

    always #5 clk = ~clk;

    pwm_capture_if #(.WIDTH(PWM_WIDTH)) cap_if ();

    pwm_capture dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pwm_in(pwm_in),
        .cap   (cap_if)
    );

    int total = 0;
    int bad = 0;

    // Reference model: pwm_in level sampled at every clock edge, plus the event bookkeeping.
    bit   lvl [MAXE];
    int   n = -1;
    int   rst_edge = -1;
    bit   in_meas = 1'b0;
    int   last_rise = 0;
    int   deadline = 0;
    logic [7:0] exp_value = '0;
    bit   exp_valid = 1'b0;
    bit   exp_stuck = 1'b0;
    bit   exp_perr = 1'b0;

    // Synchronized level seen by the capture logic just before edge m (two edges of delay).
    function automatic bit s2_at(int m);
        if (m >= 2 && (m - 2) > rst_edge) return lvl[m-2];
        return 1'b0;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s at edge %0d: got %0h want %0h", tag, n, obs, exp);
        end
    endtask

    task automatic tick(bit level, bit rn);
        bit rise;
        int per;
        int hi;
        pwm_in = level;
        rst_n  = rn;
        @(posedge clk);
        n++;
        lvl[n] = level;
        exp_valid = 1'b0;
        if (!rn) begin
            rst_edge  = n;
            in_meas   = 1'b0;
            deadline  = n + PWM_TIMEOUT;
            exp_value = '0;
            exp_stuck = 1'b0;
            exp_perr  = 1'b0;
        end else begin
            rise = s2_at(n) && !s2_at(n - 1);
            if (rise) begin
                if (in_meas) begin
                    per = n - last_rise;
                    hi = 0;
                    for (int m = last_rise; m < n; m++) hi += int'(s2_at(m));
                    exp_value = (hi > 255) ? 8'd255 : hi[7:0];
                    exp_perr  = (per != PWM_PERIOD);
                    exp_stuck = 1'b0;
                    exp_valid = 1'b1;
                end
                in_meas   = 1'b1;
                last_rise = n;
                deadline  = n + PWM_TIMEOUT - 1;
            end else if (n == deadline) begin
                exp_value = s2_at(n) ? 8'd255 : 8'd0;
                exp_stuck = 1'b1;
                exp_perr  = 1'b0;
                exp_valid = 1'b1;
                in_meas   = 1'b0;
                deadline  = n + PWM_TIMEOUT;
            end
        end
        #1;
        check("valid", cap_if.valid, exp_valid);
        check("value", cap_if.value, exp_value);
        check("stuck", cap_if.stuck, exp_stuck);
        check("period_err", cap_if.period_err, exp_perr);
        if (exp_valid) begin
            $display("edge %0d: value=%0d stuck=%0d period_err=%0d (dut value=%0d stuck=%0d period_err=%0d)",
                     n, exp_value, exp_stuck, exp_perr, cap_if.value, cap_if.stuck, cap_if.period_err);
        end
    endtask

    task automatic hold(bit level, int cycles);
        for (int i = 0; i < cycles; i++) tick(level, 1'b1);
    endtask

    task automatic pwm(int period, int high, int count);
        for (int c = 0; c < count; c++) begin
            for (int i = 0; i < period; i++) tick(i < high, 1'b1);
        end
    endtask

    initial begin
        int per;
        int hi;

        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);

        // Line low from reset: stuck-low reports every TIMEOUT cycles, then duty 15.
        hold(1'b0, 1100);
        pwm(256, 15, 3);

        // Ideal duty 30 for four periods.
        pwm(256, 30, 4);

        // Duty 1 then duty 255 back to back; the trailing periods close the 255 measurement.
        pwm(256, 1, 1);
        pwm(256, 255, 1);
        pwm(256, 30, 2);

        // Line stuck high after a measurement.
        hold(1'b1, 600);
        hold(1'b0, 10);

        // Wrong periods, including a saturating high count.
        pwm(200, 50, 3);
        pwm(300, 280, 3);

        // Reset 100 cycles into a duty-30 period.
        pwm(256, 30, 1);
        for (int i = 0; i < 100; i++) tick(i < 30, 1'b1);
        tick(1'b0, 1'b0);
        pwm(256, 30, 3);

        // Randomized duties and periods.
        for (int k = 0; k < 8; k++) begin
            per = ($urandom_range(0, 3) == 0) ? int'($urandom_range(150, 400)) : 256;
            hi  = int'($urandom_range(1, 255));
            if (hi >= per) hi = per - 1;
            pwm(per, hi, 2);
        end
        hold(1'b0, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
